// File: rtl/instruction_fetch_register_pkg.sv
// Shared types and lane-offset helper for the instruction fetch register.
// Used by the top level and by the assembly buffer.
package ir_pkg;

  typedef enum logic [0:0] {
    IR_FILL = 1'b0,
    IR_FULL = 1'b1
  } ir_state_t;

  // Bit offset of lane k inside the assembled instruction word.
  function automatic int lane_lsb(
    input int k,
    input int bus_w,
    input int instr_w,
    input bit msb_first
  );
    return msb_first ? instr_w - (k + 1) * bus_w : k * bus_w;
  endfunction

endpackage

// File: rtl/ir_assembly_buffer.sv
// Lane registers, beat counter and lane write decode.
// word_o is the buffer with the beat being written merged into its lane.
module ir_assembly_buffer
  import ir_pkg::*;
#(
  parameter int  BUS_W     = 8,
  parameter int  INSTR_W   = 16,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int BEATS     = INSTR_W / BUS_W,
  localparam int CNT_W     = $clog2(BEATS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               wr_i,
  input  logic [BUS_W-1:0]   data_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               last_o,
  output logic [INSTR_W-1:0] word_o
);

  logic [BUS_W-1:0] lane_q [BEATS];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wr_en;

  assign wr_en  = wr_i && !clr_i;
  assign last_o = (cnt_q == CNT_W'(BEATS - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wr_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      for (int k = 0; k < BEATS; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int k = 0; k < BEATS; k++) begin
        if (wr_en && cnt_q == CNT_W'(k)) begin
          lane_q[k] <= data_i;
        end
      end
    end
  end

  always_comb begin
    word_o = '0;
    for (int k = 0; k < BEATS; k++) begin
      word_o[lane_lsb(k, BUS_W, INSTR_W, MSB_FIRST) +: BUS_W] =
        (wr_en && cnt_q == CNT_W'(k)) ? data_i : lane_q[k];
    end
  end

endmodule

// File: rtl/instruction_fetch_register.sv
// Instruction register assembled from bus beats with valid/consume handshake.
// Define IR_PREFETCH_EN to overlap assembly of the next instruction.
module instruction_fetch_register
  import ir_pkg::*;
#(
  parameter int  BUS_W     = 8,
  parameter int  INSTR_W   = 16,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int BEATS     = INSTR_W / BUS_W,
  localparam int CNT_W     = $clog2(BEATS)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [BUS_W-1:0]   I,
  input  logic               Write,
  output logic               Ready,
  input  logic               Flush,
  input  logic               Consume,
  output logic [INSTR_W-1:0] IROut,
  output logic               IRValid,
  output logic [CNT_W-1:0]   BeatCount
);

  ir_state_t          state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;
  logic               accept;
  logic               last;
  logic               done;
  logic               take;
  logic [INSTR_W-1:0] word;

`ifdef IR_PREFETCH_EN
  logic pend_q, pend_d;
  assign Ready = !pend_q;
`else
  assign Ready = (state_q == IR_FILL);
`endif

  assign accept = Write && Ready && !Flush;
  assign done   = accept && last;
  assign take   = Consume && valid_q && !Flush;

  ir_assembly_buffer #(
    .BUS_W     (BUS_W),
    .INSTR_W   (INSTR_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_buf (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .clr_i  (Flush),
    .wr_i   (accept),
    .data_i (I),
    .cnt_o  (BeatCount),
    .last_o (last),
    .word_o (word)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    valid_d = valid_q;
`ifdef IR_PREFETCH_EN
    pend_d  = pend_q;
`endif
    if (Flush) begin
      state_d = IR_FILL;
      valid_d = 1'b0;
`ifdef IR_PREFETCH_EN
      pend_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IR_FILL: begin
          if (done) begin
            ir_d    = word;
            valid_d = 1'b1;
            state_d = IR_FULL;
          end
        end
        IR_FULL: begin
`ifdef IR_PREFETCH_EN
          // While pending, no beat is accepted, so word is the held buffer.
          if (pend_q) begin
            if (take) begin
              ir_d   = word;
              pend_d = 1'b0;
            end
          end else if (done && take) begin
            ir_d = word;
          end else if (done) begin
            pend_d = 1'b1;
          end else if (take) begin
            valid_d = 1'b0;
            state_d = IR_FILL;
          end
`else
          if (take) begin
            valid_d = 1'b0;
            state_d = IR_FILL;
          end
`endif
        end
        default: state_d = IR_FILL;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IR_FILL;
      ir_q    <= '0;
      valid_q <= 1'b0;
`ifdef IR_PREFETCH_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
`ifdef IR_PREFETCH_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign IROut   = ir_q;
  assign IRValid = valid_q;

endmodule

// File: tb/tb_instruction_fetch_register.sv
// Bench for instruction_fetch_register: directed steps plus random traffic
// against a beat-queue reference model; second instance covers LSB-first/32-bit.
module tb_instruction_fetch_register;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  I;
  logic        Write, Flush, Consume;
  logic        Ready, IRValid;
  logic [15:0] IROut;
  logic [0:0]  BeatCount;

  logic [7:0]  I1;
  logic        W1, Flush1, Consume1;
  logic        Ready1, IRValid1;
  logic [31:0] IROut1;
  logic [1:0]  BeatCount1;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mq[$];
  logic [15:0] m_ir, m_pw;
  bit          m_valid, m_pend;

  always #5 Clock = ~Clock;

  instruction_fetch_register #(
    .BUS_W(8), .INSTR_W(16), .MSB_FIRST(1'b1)
  ) dut0 (
    .Clock(Clock), .Reset(Reset), .I(I), .Write(Write), .Ready(Ready),
    .Flush(Flush), .Consume(Consume), .IROut(IROut), .IRValid(IRValid),
    .BeatCount(BeatCount)
  );

  instruction_fetch_register #(
    .BUS_W(8), .INSTR_W(32), .MSB_FIRST(1'b0)
  ) dut1 (
    .Clock(Clock), .Reset(Reset), .I(I1), .Write(W1), .Ready(Ready1),
    .Flush(Flush1), .Consume(Consume1), .IROut(IROut1), .IRValid(IRValid1),
    .BeatCount(BeatCount1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
`ifdef IR_PREFETCH_EN
    return !m_pend;
`else
    return !m_valid;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ir    = '0;
    m_pw    = '0;
    m_valid = 1'b0;
    m_pend  = 1'b0;
  endtask

  task automatic model_update(input logic w, input logic [7:0] d,
                              input logic f, input logic c);
    bit          acc, cons, done;
    logic [15:0] word;
    if (f) begin
      mq.delete();
      m_valid = 1'b0;
      m_pend  = 1'b0;
      return;
    end
    acc  = w && m_ready();
    cons = c && m_valid;
    done = 1'b0;
    word = '0;
    if (acc) begin
      mq.push_back(d);
      if (mq.size() == 2) begin
        word = {mq[0], mq[1]};
        mq.delete();
        done = 1'b1;
      end
    end
`ifdef IR_PREFETCH_EN
    if (cons && m_pend) begin
      m_ir   = m_pw;
      m_pend = 1'b0;
    end else if (done && !m_valid) begin
      m_ir    = word;
      m_valid = 1'b1;
    end else if (done && cons) begin
      m_ir = word;
    end else if (done) begin
      m_pend = 1'b1;
      m_pw   = word;
    end else if (cons) begin
      m_valid = 1'b0;
    end
`else
    if (done) begin
      m_ir    = word;
      m_valid = 1'b1;
    end else if (cons) begin
      m_valid = 1'b0;
    end
`endif
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ir"},    32'(IROut),     32'(m_ir));
    check({tag, ".valid"}, 32'(IRValid),   32'(m_valid));
    check({tag, ".ready"}, 32'(Ready),     32'(m_ready()));
    check({tag, ".bc"},    32'(BeatCount), 32'(mq.size()));
  endtask

  task automatic step(input string tag, input logic w, input logic [7:0] d,
                      input logic f, input logic c);
    I       = d;
    Write   = w;
    Flush   = f;
    Consume = c;
    @(posedge Clock);
    model_update(w, d, f, c);
    #1;
    Write   = 1'b0;
    Flush   = 1'b0;
    Consume = 1'b0;
    check_model(tag);
  endtask

  task automatic step1(input logic [7:0] d, input logic [1:0] bc);
    I1 = d;
    W1 = 1'b1;
    @(posedge Clock);
    #1;
    W1 = 1'b0;
    check("lsb.bc", 32'(BeatCount1), 32'(bc));
  endtask

  initial begin
    Reset = 1'b1;
    I = '0; Write = 0; Flush = 0; Consume = 0;
    I1 = '0; W1 = 0; Flush1 = 0; Consume1 = 0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    check_model("rst0");

    // basic load
    step("ld0", 1, 8'hA5, 0, 0);
    step("ld1", 1, 8'h3C, 0, 0);
    check("basic.ir", 32'(IROut), 32'h0000_A53C);
    check("basic.valid", 32'(IRValid), 32'd1);
`ifndef IR_PREFETCH_EN
    check("basic.ready", 32'(Ready), 32'd0);
`endif
    step("cons", 0, 8'h00, 0, 1);
    check("cons.valid", 32'(IRValid), 32'd0);

    // async reset mid-cycle with a partial beat held
    step("part", 1, 8'h12, 0, 0);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check("arst.ir", 32'(IROut), 32'h0);
    check("arst.valid", 32'(IRValid), 32'd0);
    check("arst.ready", 32'(Ready), 32'd1);
    check("arst.bc", 32'(BeatCount), 32'd0);
    #2 Reset = 1'b0;

    // stall and flush
    step("s0", 1, 8'hA5, 0, 0);
    step("s1", 1, 8'h3C, 0, 0);
    step("stall", 1, 8'hFF, 0, 0);
    check("stall.ir", 32'(IROut), 32'h0000_A53C);
    step("scons", 0, 8'h00, 0, 1);
    step("sflush", 0, 8'h00, 1, 0);
    step("f0", 1, 8'h12, 0, 0);
    check("f0.bc", 32'(BeatCount), 32'd1);
    step("flush", 1, 8'h34, 1, 1);
    check("flush.bc", 32'(BeatCount), 32'd0);
    check("flush.valid", 32'(IRValid), 32'd0);
    check("flush.ir", 32'(IROut), 32'h0000_A53C);
    step("b0", 1, 8'hBE, 0, 0);
    step("b1", 1, 8'hEF, 0, 0);
    check("beef.ir", 32'(IROut), 32'h0000_BEEF);

    // LSB-first 32-bit lane order
    check("lsb.bc0", 32'(BeatCount1), 32'd0);
    step1(8'h11, 2'd1);
    step1(8'h22, 2'd2);
    step1(8'h33, 2'd3);
    check("lsb.novalid", 32'(IRValid1), 32'd0);
    step1(8'h44, 2'd0);
    check("lsb.ir", IROut1, 32'h4433_2211);
    check("lsb.valid", 32'(IRValid1), 32'd1);

`ifdef IR_PREFETCH_EN
    step("pclr", 0, 8'h00, 1, 0);
    step("p0", 1, 8'h12, 0, 0);
    step("p1", 1, 8'h34, 0, 0);
    step("p2", 1, 8'h56, 0, 0);
    step("p3", 1, 8'h78, 0, 0);
    check("pend.ready", 32'(Ready), 32'd0);
    check("pend.ir", 32'(IROut), 32'h0000_1234);
    step("pcons", 0, 8'h00, 0, 1);
    check("pcons.ir", 32'(IROut), 32'h0000_5678);
    check("pcons.valid", 32'(IRValid), 32'd1);
    step("q0", 1, 8'hBC, 0, 0);
    step("q1", 1, 8'h9A, 0, 1);
    check("same.ir", 32'(IROut), 32'h0000_BC9A);
    check("same.valid", 32'(IRValid), 32'd1);
`endif

    for (int n = 0; n < 400; n++) begin
      step("rnd",
           1'($urandom_range(0, 9) < 7),
           8'($urandom),
           1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 9) < 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
